// File: rtl/peripheral_ahb4_slave_mem.sv
// AHB-Lite slave memory. Word-addressed array behind an AHB4 port, with programmable
// wait states, the two-cycle ERROR response and read-after-write forwarding.
module peripheral_ahb4_slave_mem #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);
  localparam int BYTE_LANES = HDATA_SIZE / 8;
  localparam int LANE_BITS  = $clog2(BYTE_LANES);
  localparam int WORD_BITS  = $clog2(MEM_DEPTH);
  localparam int ADDR_BITS  = LANE_BITS + WORD_BITS;
  localparam int MEM_BYTES  = MEM_DEPTH * BYTE_LANES;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  dp_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [HDATA_SIZE-1:0] hrdata_q;
  logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  logic                  accept_s;
  logic                  illegal_s;
  logic                  idle_like_s;
  logic                  wr_now_s;
  logic [BYTE_LANES-1:0] wr_strb_s;
  logic [BYTE_LANES-1:0] fwd_strb_s;
  logic [WORD_BITS-1:0]  wr_idx_s;
  logic [WORD_BITS-1:0]  rd_idx_s;
  logic                  rd_load_s;
  logic [HDATA_SIZE-1:0] rd_word_s;
  logic                  unused_s;

  function automatic logic is_illegal(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
    logic [HADDR_SIZE-1:0] align_m;
    align_m = (HADDR_SIZE'(1) << size) - HADDR_SIZE'(1);
    return (addr >= HADDR_SIZE'(MEM_BYTES)) || ((addr & align_m) != '0) ||
           ((32'd8 << size) > 32'(HDATA_SIZE));
  endfunction

  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [2:0] size,
                                                      input logic [LANE_BITS-1:0] off);
    logic [BYTE_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < BYTE_LANES; k++) begin
      if ((k >= int'(off)) && (k < int'(off) + (32'sd1 << size))) m[k] = 1'b1;
      else m[k] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [HDATA_SIZE-1:0] merge_lanes(input logic [HDATA_SIZE-1:0] old_w,
                                                        input logic [HDATA_SIZE-1:0] new_w,
                                                        input logic [BYTE_LANES-1:0] strb);
    logic [HDATA_SIZE-1:0] res;
    res = old_w;
    for (int k = 0; k < BYTE_LANES; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign accept_s    = HSEL & HREADY & HTRANS[1];
  assign illegal_s   = is_illegal(HADDR, HSIZE);
  assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign wr_now_s    = dp_q & write_q & hreadyout_q & ~hresp_q;
  assign wr_strb_s   = lane_mask(size_q, addr_q[LANE_BITS-1:0]);
  assign wr_idx_s    = addr_q[ADDR_BITS-1:LANE_BITS];
  assign unused_s    = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

  // Read word selection; a write completing this cycle to the same word is merged in.
  always_comb begin
    if (state_q == ST_WAIT) rd_idx_s = wr_idx_s;
    else rd_idx_s = HADDR[ADDR_BITS-1:LANE_BITS];
    if (wr_now_s && (wr_idx_s == rd_idx_s)) fwd_strb_s = wr_strb_s;
    else fwd_strb_s = '0;
    rd_word_s = merge_lanes(mem_q[rd_idx_s], HWDATA, fwd_strb_s);
    if (state_q == ST_WAIT) rd_load_s = (cnt_q == 4'd0) && !write_q;
    else if (idle_like_s) rd_load_s = accept_s && !illegal_s && !HWRITE && (WAIT_STATES == 0);
    else rd_load_s = 1'b0;
  end

  // Transfer FSM with registered bus responses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      dp_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      if (rd_load_s) hrdata_q <= rd_word_s;
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        ST_IDLE, ST_ERR2: begin
          if (accept_s) begin
            addr_q  <= HADDR[ADDR_BITS-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (illegal_s) begin
              state_q     <= ST_ERR1;
              dp_q        <= 1'b0;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= ST_WAIT;
              cnt_q       <= WAIT_INIT;
              dp_q        <= 1'b1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= ST_IDLE;
              dp_q        <= 1'b1;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= ST_IDLE;
            dp_q        <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          dp_q        <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write into the array in the write's completion cycle.
  always_ff @(posedge HCLK) begin
    if (wr_now_s) mem_q[wr_idx_s] <= merge_lanes(mem_q[wr_idx_s], HWDATA, wr_strb_s);
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
endmodule

// File: tb/tb_peripheral_ahb4_slave_mem.sv
// Bench for peripheral_ahb4_slave_mem: a zero-wait and a two-wait instance driven by a
// pipelined AHB master, checked against a byte-array reference model.
module tb_peripheral_ahb4_slave_mem;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        rdy0, rdy1, resp0, resp1;
  logic [31:0] rdata0, rdata1;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [2:0]  burst;
  } xfer_t;

  xfer_t       q[$];
  logic [7:0]  mdl [2][1024];
  int          errors = 0;
  int          checks = 0;
  int          dp_cycles;
  logic [31:0] last_rd;

  always #5 HCLK = ~HCLK;

  peripheral_ahb4_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
    .HWDATA(hwdata), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  peripheral_ahb4_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
    .HWDATA(hwdata), .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws(input int t);
    return (t == 0) ? 0 : 2;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] s);
    int bytes = 1 << s;
    return (a >= 32'd1024) || ((a % 32'(bytes)) != 32'd0) || (bytes > 4);
  endfunction

  function automatic logic [31:0] mdl_word(input int t, input logic [31:0] a);
    int b = int'(a) & ~3;
    return {mdl[t][b+3], mdl[t][b+2], mdl[t][b+1], mdl[t][b]};
  endfunction

  task automatic mdl_write(input int t, input logic [31:0] a, input logic [2:0] s, input logic [31:0] w);
    for (int k = 0; k < (1 << s); k++) begin
      int b = int'(a) + k;
      mdl[t][b] = w[8*(b%4) +: 8];
    end
  endtask

  task automatic add(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] w, input logic [2:0] bu);
    q.push_back('{sel, tr, wr, a, s, w, bu});
  endtask

  task automatic drive_addr(input int tgt, input int i);
    hsel = 2'b00;
    if (i < q.size()) begin
      hsel[tgt] = q[i].sel;
      htrans    = q[i].trans;
      hwrite    = q[i].wr;
      haddr     = q[i].addr;
      hsize     = q[i].size;
      hburst    = q[i].burst;
    end else begin
      htrans = 2'b00;
      hwrite = 1'b0;
      haddr  = 32'd0;
      hsize  = 3'd2;
      hburst = 3'd0;
    end
  endtask

  // Pipelined master: runs the queued transfers on one instance, checking each data phase.
  task automatic run(input int tgt);
    int ap, dp, low;
    logic dp_act, prev_r, r, rs, ee, low_ok, done;
    logic [31:0] rd;
    ap = 0; dp = 0; low = 0; dp_act = 1'b0; prev_r = 1'b1; low_ok = 1'b1; done = 1'b0;
    dp_cycles = 0;
    drive_addr(tgt, ap);
    for (int g = 0; g < 2000; g++) begin
      @(posedge HCLK); #1;
      if (prev_r) begin
        if (ap >= q.size()) begin
          done = 1'b1;
          break;
        end
        dp = ap;
        dp_act = q[ap].sel && q[ap].trans[1];
        ap++;
        low = 0;
        low_ok = 1'b1;
        drive_addr(tgt, ap);
        hwdata = dp_act ? q[dp].wdata : $urandom;
      end
      r  = (tgt == 0) ? rdy0 : rdy1;
      rs = (tgt == 0) ? resp0 : resp1;
      rd = (tgt == 0) ? rdata0 : rdata1;
      if (!dp_act) begin
        chk("idle_ready_resp", {30'd0, r, rs}, {30'd0, 1'b1, 1'b0});
      end else begin
        dp_cycles++;
        ee = exp_err(q[dp].addr, q[dp].size);
        if (!r) begin
          low++;
          if (rs !== ee) low_ok = 1'b0;
        end else begin
          chk("resp", {31'd0, rs}, {31'd0, ee});
          chk("wait_cycles", low, ee ? 1 : ws(tgt));
          chk("wait_resp", {31'd0, low_ok}, 32'd1);
          if (!ee && !q[dp].wr) begin
            chk("rdata", rd, mdl_word(tgt, q[dp].addr));
            last_rd = rd;
          end
          if (!ee && q[dp].wr) mdl_write(tgt, q[dp].addr, q[dp].size, q[dp].wdata);
        end
      end
      prev_r = r;
    end
    chk("run_done", {31'd0, done}, 32'd1);
    q.delete();
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    logic [2:0] s;
    logic [1:0] tr;
    HRESET = 1'b1; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'd0;
    drive_addr(0, 0);
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_ready0", {31'd0, rdy0}, 32'd1);
    chk("reset_resp0", {31'd0, resp0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_ready1", {31'd0, rdy1}, 32'd1);
    chk("reset_resp1", {31'd0, resp1}, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    HRESET = 1'b0;

    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 32; w++) add(1'b1, 2'b10, 1'b1, 32'(w * 4), 3'd2, $urandom, 3'd1);
      run(t);
    end

    add(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, 3'd0);
    run(0);
    chk("raw_word", last_rd, 32'hDEADBEEF);

    add(1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hAA000000, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, 3'd0);
    run(0);
    chk("byte_merge", last_rd, 32'hAAADBEEF);
    add(1'b1, 2'b10, 1'b1, 32'h10, 3'd1, 32'h00005555, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, 3'd0);
    run(0);
    chk("half_merge", last_rd, 32'hAAAD5555);

    add(1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'd0, 3'd3);
    for (int b = 1; b < 4; b++) add(1'b1, 2'b11, 1'b0, 32'(32'h40 + b * 4), 3'd2, 32'd0, 3'd3);
    run(1);
    chk("incr4_cycles", dp_cycles, 32'd12);

    add(1'b1, 2'b10, 1'b1, 32'h400, 3'd2, 32'h12345678, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h01, 3'd1, 32'd0, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, 3'd0);
    run(0);
    chk("after_errors", last_rd, 32'hAAAD5555);

    add(1'b1, 2'b00, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 3'd0);
    add(1'b1, 2'b01, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 3'd0);
    add(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 3'd0);
    add(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, 3'd0);
    run(0);
    chk("no_select_write", last_rd, 32'hAAAD5555);

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 30; i++) begin
        kind = int'($urandom_range(0, 9));
        s = 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 127)) & ~((32'd1 << s) - 32'd1);
        if (kind == 0) a = 32'h400 + 32'($urandom_range(0, 63)) * 32'd4;
        if (kind == 1) s = 3'd3;
        if (kind == 2) begin
          s = 3'd2;
          a = a | 32'd1;
        end
        tr = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        if (kind == 4) tr = 2'($urandom_range(0, 1));
        add(kind != 3, tr, 1'($urandom_range(0, 1)), a, s, $urandom, 3'd1);
      end
      run(t);
    end

    add(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h11111111, 3'd0);
    run(1);
    hsel = 2'b10; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    @(posedge HCLK); #1;
    drive_addr(1, 0);
    hwdata = 32'h22222222;
    chk("abort_in_wait", {31'd0, rdy1}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    chk("abort_ready", {31'd0, rdy1}, 32'd1);
    chk("abort_resp", {31'd0, resp1}, 32'd0);
    chk("abort_rdata", rdata1, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    add(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'd0, 3'd0);
    run(1);
    chk("abort_discarded", last_rd, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/peripheral_ahb4_slave_mem.md
Name: peripheral_ahb4_slave_mem

Overview:
- AHB-Lite (AMBA4) slave memory model: the responder end of the AHB4 bus functional model.
- Accepts NONSEQ/SEQ transfers from the master BFM and stores data in an internal word-addressed array.
- Inserts a programmable number of wait states.
- Issues the two-cycle ERROR response for illegal transfers.
- Sits in the UVM bench as the DUT-side target behind the AHB4 interface.

Parameters:
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width (32 or 64); byte lanes = HDATA_SIZE/8.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words; valid byte range is 0 .. MEM_DEPTH*HDATA_SIZE/8-1.
- WAIT_STATES, 0, wait cycles inserted before the OKAY completion of every active transfer (0..15).

Ports:
- HCLK  in  1  bus clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  transfer address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type; informational only, not checked.
- HPROT  in  4  protection; ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  HDATA_SIZE  write data, data phase.
- HREADY  in  1  bus-level ready; an address phase is accepted only when high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  HDATA_SIZE  read data, valid while HREADYOUT=1 and HRESP=0 in a read data phase.

Behaviour:
- Reset (asynchronous, any cycle):
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
  - A pending write is discarded. Array contents are not reset.
- Address-phase acceptance:
  - Accept = HSEL & HREADY & HTRANS[1].
  - On accept, register HADDR, HWRITE and HSIZE, and the error flag.
  - IDLE/BUSY, or HSEL=0, with HREADY=1: FSM returns to IDLE; zero-wait OKAY.
- Error conditions (decided at accept):
  - Address outside the valid range, OR
  - HADDR not a multiple of 2^HSIZE, OR
  - 2^HSIZE*8 > HDATA_SIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - Accepted error transfer -> ERR1.
  - Accepted legal transfer with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Accepted legal transfer with WAIT_STATES=0 -> completes in the next cycle; FSM stays IDLE.
- WAIT:
  - HREADYOUT=0, HRESP=0; counter decrements each cycle.
  - At counter=0, next cycle is the completion cycle: HREADYOUT=1, HRESP=0.
  - A new address phase may be accepted in the completion cycle (pipelined).
- ERR1: HREADYOUT=0, HRESP=1, always -> ERR2.
- ERR2:
  - HREADYOUT=1, HRESP=1.
  - A new accept in this cycle is processed as from IDLE; otherwise -> IDLE.
- Errored transfers never modify the array; HRDATA is held at its previous value during an error.
- Error responses never insert WAIT_STATES.
- Write:
  - HWDATA is sampled only in the completion cycle (HREADYOUT=1, HRESP=0).
  - Only the 2^HSIZE byte lanes selected by HADDR[log2(lanes)-1:0] are updated, little-endian: byte at offset k is on HWDATA[8k+7:8k].
- Read:
  - HRDATA presents the full word at the registered word address; all lanes are driven.
  - Master extracts the lanes it needs.
- Read-after-write hazard: a read whose address phase overlaps the data phase of a write to the same word returns the merged (post-write) word, via forwarding.
- HRDATA is not required to change outside read completion cycles.
- Address phases presented while HREADY=0 are ignored.

Test Plan:
1. Assert HRESET mid-WAIT of a write to 0x20 (WAIT_STATES=2) -> outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0; subsequent read of 0x20 does not return the aborted data.
2. WAIT_STATES=0: word write 0xDEADBEEF @0x10, then back-to-back NONSEQ word read @0x10 -> HRDATA=0xDEADBEEF in the read's first data-phase cycle, HREADYOUT=1 throughout.
3. Byte write HSIZE=000 @0x13 with HWDATA=0xAA000000, then word read @0x10 -> 0xAAADBEEF. Halfword write 0x5555 @0x10 on HWDATA[15:0], then word read @0x10 -> 0xAAAD5555.
4. WAIT_STATES=2: INCR4 word read @0x40..0x4C -> each beat shows HREADYOUT 0,0,1; 12 data-phase cycles total; data matches prior writes.
5. MEM_DEPTH=256: word write @0x400 -> HREADYOUT/HRESP = 0/1 then 1/1. Halfword read @0x01 -> same two-cycle ERROR. Word read @0x10 afterwards -> 0xAAAD5555 unchanged.
6. HSEL=1 with HTRANS=IDLE, then BUSY, then HSEL=0 with NONSEQ write @0x10 of 0xFFFFFFFF -> HREADYOUT=1, HRESP=0 every cycle; read @0x10 still returns 0xAAAD5555.
